spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller_if.sv | 23 ++
 rtl/spi_controller.sv | 129 ++++++++++++
 tb/tb_spi_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Host-side request/response bundle and SPI pins of spi_controller.
// master drives requests; slave is the controller itself.
interface spi_controller_if;
   logic       start;
   logic       wr;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic       SCLK;
   logic       COPI;
   logic       nCS;

   modport master (
      output start, wr, addr, wdata,
      input  busy, done, SCLK, COPI, nCS
   );

   modport slave (
      input  start, wr, addr, wdata,
      output busy, done, SCLK, COPI, nCS
   );
endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI write controller: shifts one 16-bit {wr,addr,wdata}
// frame MSB first, all pins registered.
module spi_controller #(
   parameter int unsigned CLK_DIV = 4
) (
   input logic             clk,
   input logic             rst,
   spi_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      GAP
   } state_t;

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] frame_q, frame_d;
   logic        sclk_q, sclk_d;
   logic        copi_q, copi_d;
   logic        ncs_q, ncs_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        last;
   logic [3:0]  nxt;

   assign last = (phase_q == LAST);
   assign nxt  = bit_q - 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= 8'd0;
         bit_q   <= 4'd0;
         frame_q <= 16'd0;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         ncs_q   <= ncs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Outputs are computed for the next state so every pin is a flop.
   always_comb begin
      state_d = state_q;
      phase_d = last ? 8'd0 : phase_q + 8'd1;
      bit_d   = bit_q;
      frame_d = frame_q;
      sclk_d  = sclk_q;
      copi_d  = copi_q;
      ncs_d   = ncs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            phase_d = 8'd0;
            if (bus.start) begin
               frame_d = {bus.wr, bus.addr, bus.wdata};
               state_d = SETUP;
               bit_d   = 4'd15;
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
               copi_d  = bus.wr;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            if (last) begin
               state_d = HIGH;
               sclk_d  = 1'b1;
            end
         end
         HIGH: begin
            if (last) begin
               state_d = LOW;
               sclk_d  = 1'b0;
               copi_d  = (bit_q == 4'd0) ? frame_q[0]
                                         : frame_q[nxt];
            end
         end
         // Final LOW after bit 0 doubles as chip-select hold.
         LOW: begin
            if (last) begin
               if (bit_q == 4'd0) begin
                  state_d = GAP;
                  ncs_d   = 1'b1;
                  copi_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = HIGH;
                  sclk_d  = 1'b1;
                  bit_d   = nxt;
               end
            end
         end
         GAP: begin
            if (last) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.SCLK = sclk_q;
   assign bus.COPI = copi_q;
   assign bus.nCS  = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: CLK_DIV=4 and CLK_DIV=3
// instances, 2-flop-synchronised peripheral model and frame scoreboard.
module tb_spi_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   spi_controller_if bif4 ();
   spi_controller_if bif3 ();

   spi_controller #(.CLK_DIV(4)) dut4 (
      .clk(clk),
      .rst(rst),
      .bus(bif4)
   );

   spi_controller #(.CLK_DIV(3)) dut3 (
      .clk(clk),
      .rst(rst),
      .bus(bif3)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] q4[$];
   logic [15:0] q3[$];
   logic [7:0]  regs[128];
   logic        abort_ok = 1'b0;

   logic [1:0] sclk_w, copi_w, ncs_w, done_w, busy_w;
   assign sclk_w = {bif3.SCLK, bif4.SCLK};
   assign copi_w = {bif3.COPI, bif4.COPI};
   assign ncs_w  = {bif3.nCS, bif4.nCS};
   assign done_w = {bif3.done, bif4.done};
   assign busy_w = {bif3.busy, bif4.busy};

   int          rises[2]   = '{0, 0};
   int          dones[2]   = '{0, 0};
   int          ncs_hi[2]  = '{0, 0};
   int          cnt[2]     = '{0, 0};
   logic [15:0] sh[2]      = '{16'd0, 16'd0};
   logic        sclk_p[2]  = '{1'b0, 1'b0};
   logic        ncs_p[2]   = '{1'b1, 1'b1};
   logic        s_sclk1[2] = '{1'b0, 1'b0};
   logic        s_sclk2[2] = '{1'b0, 1'b0};
   logic        s_copi1[2] = '{1'b0, 1'b0};
   logic        s_copi2[2] = '{1'b0, 1'b0};
   logic        s_ncs1[2]  = '{1'b1, 1'b1};
   logic        s_ncs2[2]  = '{1'b1, 1'b1};
   logic        ps, pn, got;
   logic [15:0] e;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pin monitor plus peripheral model sampling through two flops.
   always begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (sclk_w[k] && !sclk_p[k]) rises[k]++;
         if (done_w[k]) dones[k]++;
         if (ncs_w[k]) ncs_hi[k]++;
         if (!ncs_w[k] && ncs_p[k]) begin
            chk("ncs_gap", 32'(ncs_hi[k] >= 3), 32'd1);
            ncs_hi[k] = 0;
            rises[k]  = 0;
         end
         if (ncs_w[k] && !ncs_p[k] && !abort_ok)
            chk("sclk_rises", rises[k], 32'd16);
         sclk_p[k] = sclk_w[k];
         ncs_p[k]  = ncs_w[k];

         ps = s_sclk2[k];
         pn = s_ncs2[k];
         s_sclk2[k] = s_sclk1[k];
         s_sclk1[k] = sclk_w[k];
         s_copi2[k] = s_copi1[k];
         s_copi1[k] = copi_w[k];
         s_ncs2[k]  = s_ncs1[k];
         s_ncs1[k]  = ncs_w[k];
         if (!s_ncs2[k] && pn) cnt[k] = 0;
         if (!s_ncs2[k] && s_sclk2[k] && !ps) begin
            sh[k] = {sh[k][14:0], s_copi2[k]};
            cnt[k]++;
         end
         if (s_ncs2[k] && !pn) begin
            if (cnt[k] == 16) begin
               got = 1'b0;
               if (k == 0 && q4.size() > 0) begin
                  e = q4.pop_front();
                  got = 1'b1;
               end
               if (k == 1 && q3.size() > 0) begin
                  e = q3.pop_front();
                  got = 1'b1;
               end
               chk("sb_expected", 32'(got), 32'd1);
               if (got) chk(k == 0 ? "frame4" : "frame3", sh[k], e);
               if (sh[k][15]) regs[sh[k][14:8]] = sh[k][7:0];
            end else if (!abort_ok) begin
               chk("frame_len", cnt[k], 32'd16);
            end
         end
      end
   end

   task automatic send4(input logic w, input logic [6:0] a,
                        input logic [7:0] d);
      bif4.start = 1'b1;
      bif4.wr    = w;
      bif4.addr  = a;
      bif4.wdata = d;
      @(posedge clk);
      #1;
      bif4.start = 1'b0;
   endtask

   task automatic wait_idle(input int k, input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (!busy_w[k]) break;
      end
      chk("idle_timeout", busy_w[k], 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) regs[i] = 8'h3C;
      bif4.start = 1'b0; bif4.wr = 1'b0;
      bif4.addr  = 7'd0; bif4.wdata = 8'd0;
      bif3.start = 1'b0; bif3.wr = 1'b0;
      bif3.addr  = 7'd0; bif3.wdata = 8'd0;

      repeat (4) @(posedge clk);
      #1;
      chk("rst_ncs",  bif4.nCS,  32'd1);
      chk("rst_sclk", bif4.SCLK, 32'd0);
      chk("rst_copi", bif4.COPI, 32'd0);
      chk("rst_busy", bif4.busy, 32'd0);
      chk("rst_done", bif4.done, 32'd0);

      // Frame 0x80A5 accepted on first edge after reset release.
      @(negedge clk);
      rst = 1'b0;
      q4.push_back(16'h80A5);
      send4(1'b1, 7'h00, 8'hA5);
      bif4.addr  = 7'h33;
      bif4.wdata = 8'h00;
      chk("a_ncs_t1",  bif4.nCS,  32'd0);
      chk("a_busy_t1", bif4.busy, 32'd1);
      chk("a_copi_t1", bif4.COPI, 32'd1);
      chk("a_sclk_t1", bif4.SCLK, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("a_sclk_t5", bif4.SCLK, 32'd1);
      repeat (127) @(posedge clk);
      #1;
      chk("a_ncs_t132",  bif4.nCS,  32'd0);
      chk("a_done_t132", bif4.done, 32'd0);
      @(posedge clk);
      #1;
      chk("a_ncs_t133",  bif4.nCS,  32'd1);
      chk("a_done_t133", bif4.done, 32'd1);
      chk("a_sclk_t133", bif4.SCLK, 32'd0);
      chk("a_copi_t133", bif4.COPI, 32'd0);
      @(posedge clk);
      #1;
      chk("a_done_t134", bif4.done, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("a_busy_t136", bif4.busy, 32'd1);
      @(posedge clk);
      #1;
      chk("a_busy_t137", bif4.busy, 32'd0);
      chk("a_reg00", regs[0], 32'hA5);
      chk("a_dones", dones[0], 32'd1);
      chk("a_q4", q4.size(), 32'd0);

      // Back-to-back write of the duty-cycle register.
      q4.push_back(16'h84FF);
      send4(1'b1, 7'h04, 8'hFF);
      wait_idle(0, 300);
      repeat (3) @(posedge clk);
      chk("b_reg04", regs[4], 32'hFF);
      chk("b_q4", q4.size(), 32'd0);

      // Read frame shifts identically, model untouched.
      q4.push_back(16'h7F00);
      send4(1'b0, 7'h7F, 8'h00);
      wait_idle(0, 300);
      repeat (3) @(posedge clk);
      chk("c_reg7f", regs[127], 32'h3C);
      chk("c_reg04", regs[4], 32'hFF);
      chk("c_dones", dones[0], 32'd3);

      // Start while busy is ignored.
      q4.push_back(16'h1234);
      send4(1'b0, 7'h12, 8'h34);
      repeat (49) @(posedge clk);
      #1;
      send4(1'b1, 7'h55, 8'hAA);
      wait_idle(0, 300);
      repeat (10) @(posedge clk);
      #1;
      chk("d_no_queue", bif4.busy, 32'd0);
      chk("d_dones", dones[0], 32'd4);
      chk("d_q4", q4.size(), 32'd0);
      chk("d_reg55", regs[7'h55], 32'h3C);

      // Reset mid-frame aborts without done.
      abort_ok = 1'b1;
      send4(1'b1, 7'h19, 8'h99);
      repeat (59) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("e_ncs_async",  bif4.nCS,  32'd1);
      chk("e_sclk_async", bif4.SCLK, 32'd0);
      chk("e_busy_async", bif4.busy, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort_ok = 1'b0;
      chk("e_no_done", dones[0], 32'd4);
      chk("e_reg19", regs[7'h19], 32'h3C);
      q4.push_back(16'h8155);
      send4(1'b1, 7'h01, 8'h55);
      wait_idle(0, 300);
      repeat (3) @(posedge clk);
      chk("e_reg01", regs[1], 32'h55);
      chk("e_q4", q4.size(), 32'd0);
      chk("e_dones", dones[0], 32'd5);

      // CLK_DIV=3 with start held: three back-to-back frames.
      for (int i = 0; i < 3; i++) q3.push_back(16'h8233);
      bif3.start = 1'b1;
      bif3.wr    = 1'b1;
      bif3.addr  = 7'h02;
      bif3.wdata = 8'h33;
      @(posedge clk);
      repeat (216) @(posedge clk);
      #1;
      bif3.start = 1'b0;
      wait_idle(1, 400);
      repeat (3) @(posedge clk);
      chk("f_dones", dones[1], 32'd3);
      chk("f_q3", q3.size(), 32'd0);
      chk("f_reg02", regs[2], 32'h33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
